mem_stage: RTL and testbench

//  MEM pipeline stage directly downstream of the EX stage. Consumes the EX/MEM register

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Takes the EX/MEM register outputs and drives
//            a req/ack data-memory port. A two-state stall FSM (IDLE/WAIT)
//            covers multi-cycle memory. Results go into the MEM/WB register,
//            and the branch decision and target are forwarded. The stage
//            flags misaligned accesses and memory timeouts.
// Ports    : clk, rst (async, active-high)
//            ex_*           - EX/MEM register outputs (control, data, tags)
//            dmem_*         - registered req/we/addr/wdata out; ack/rdata in
//            mem_stall      - combinational freeze request to the hazard unit
//            mem_*          - MEM/WB register, branch/target, debug tags
//            mem_misalign   - one-cycle pulse on a misaligned access
//            mem_err        - one-cycle pulse on a memory timeout abort
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [4:0]  ex_destR,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_rdata,
  output logic [4:0]  mem_destR,
  output logic        mem_branch,
  output logic [31:0] mem_pc,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        mem_misalign,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Last WAIT count value before the access is abandoned.
  localparam logic [7:0] C_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] r_cnt;

  logic w_acc;
  logic w_misal;
  logic w_pass;    // IDLE: instruction flows straight through (incl. misaligned bubble)
  logic w_start;   // IDLE: issue memory request, enter WAIT
  logic w_done;    // WAIT: ack received, retire the frozen instruction
  logic w_abort;   // WAIT: timeout reached without ack

  assign w_acc   = ex_m2reg | ex_wmem;
  assign w_misal = (ex_aluR[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    w_pass    = 1'b0;
    w_start   = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (w_acc && !w_misal) begin
          mem_stall = 1'b1;
          w_start   = 1'b1;
          state_nxt = WAIT;
        end else begin
          w_pass = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          w_done    = 1'b1;
          state_nxt = IDLE;
        end else if (r_cnt == C_LAST_WAIT) begin
          // Release the pipeline in the same cycle the abort is decided.
          w_abort   = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The hazard unit must not see a freeze while the stage is being reset.
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (state == WAIT && !dmem_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Memory port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
    end else if (w_start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= ex_wmem;
      dmem_addr  <= {ex_aluR[31:2], 2'b00};
      dmem_wdata <= ex_inB;
    end else if (w_done || w_abort) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end
  end

  // MEM/WB register, branch forwarding and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wreg       <= 1'b0;
      mem_m2reg      <= 1'b0;
      mem_aluR       <= 32'd0;
      mem_rdata      <= 32'd0;
      mem_destR      <= 5'd0;
      mem_branch     <= 1'b0;
      mem_pc         <= 32'd0;
      MEM_ins_type   <= 4'd0;
      MEM_ins_number <= 4'd0;
      mem_misalign   <= 1'b0;
      mem_err        <= 1'b0;
    end else begin
      mem_misalign <= 1'b0;
      mem_err      <= 1'b0;
      if (w_pass || w_done || w_start) begin
        mem_aluR       <= ex_aluR;
        mem_destR      <= ex_destR;
        mem_pc         <= ex_pc;
        MEM_ins_type   <= EXE_ins_type;
        MEM_ins_number <= EXE_ins_number;
      end
      if (w_pass) begin
        // A misaligned access is squashed to a bubble instead of touching memory.
        mem_wreg     <= ex_wreg & ~w_acc;
        mem_m2reg    <= ex_m2reg & ~w_acc;
        mem_rdata    <= 32'd0;
        mem_branch   <= ex_branch;
        mem_misalign <= w_acc & w_misal;
      end else if (w_done) begin
        mem_wreg   <= ex_wreg;
        mem_m2reg  <= ex_m2reg;
        mem_rdata  <= ex_m2reg ? dmem_rdata : 32'd0;
        mem_branch <= ex_branch;
      end else if (w_start || w_abort) begin
        mem_wreg   <= 1'b0;
        mem_m2reg  <= 1'b0;
        mem_rdata  <= 32'd0;
        mem_branch <= 1'b0;
        mem_err    <= w_abort;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage (TIMEOUT=4). Each instruction
//            is treated as a transaction whose expected cycle-by-cycle outputs
//            follow from its class (ALU, misaligned, memory access) and from
//            the chosen ack latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch;
  logic [31:0] ex_aluR, ex_inB, ex_pc;
  logic [4:0]  ex_destR;
  logic [3:0]  EXE_ins_type, EXE_ins_number;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, mem_stall, mem_wreg, mem_m2reg, mem_branch;
  logic [31:0] dmem_addr, dmem_wdata, mem_aluR, mem_rdata, mem_pc;
  logic [4:0]  mem_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;
  logic        mem_misalign, mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_branch(ex_branch), .ex_pc(ex_pc),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .mem_stall(mem_stall),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_aluR(mem_aluR),
    .mem_rdata(mem_rdata), .mem_destR(mem_destR), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .MEM_ins_type(MEM_ins_type),
    .MEM_ins_number(MEM_ins_number), .mem_misalign(mem_misalign),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [31:0] alu, input logic [31:0] inb,
                        input logic [4:0] dest, input logic br, input logic [31:0] pc);
    ex_wreg = wreg; ex_m2reg = m2reg; ex_wmem = wmem;
    ex_aluR = alu; ex_inB = inb; ex_destR = dest; ex_branch = br; ex_pc = pc;
    EXE_ins_type = 4'($urandom); EXE_ins_number = 4'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 0);
    chk({tag, "_stall"}, 32'(mem_stall), 0);
    chk({tag, "_ctl"}, {24'd0, mem_wreg, mem_m2reg, mem_branch, mem_misalign, mem_err, dmem_we, 2'd0}, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_aluR"}, mem_aluR, 0);
    chk({tag, "_rdata"}, mem_rdata, 0);
    chk({tag, "_pc"}, mem_pc, 0);
    chk({tag, "_dest_tags"}, {19'd0, mem_destR, MEM_ins_type, MEM_ins_number}, 0);
  endtask

  // Called at a falling edge with ex_* already driven. delay = number of WAIT
  // cycles before ack; delay >= TO means memory never answers.
  task automatic run_txn(input int delay, input logic [31:0] rd);
    logic acc, mis, fin;
    acc = ex_m2reg | ex_wmem;
    mis = (ex_aluR[1:0] != 2'b00);
    dmem_ack = 1'b0;
    #1;
    if (!acc || mis) begin
      chk("pass_stall", 32'(mem_stall), 0);
      @(posedge clk); @(negedge clk);
      chk("pass_wreg", 32'(mem_wreg), 32'(ex_wreg & ~acc));
      chk("pass_m2reg", 32'(mem_m2reg), 0);
      chk("pass_aluR", mem_aluR, ex_aluR);
      chk("pass_dest", 32'(mem_destR), 32'(ex_destR));
      chk("pass_branch", 32'(mem_branch), 32'(ex_branch));
      chk("pass_pc", mem_pc, ex_pc);
      chk("pass_tags", {MEM_ins_type, MEM_ins_number}, {EXE_ins_type, EXE_ins_number});
      chk("pass_misalign", 32'(mem_misalign), 32'(acc & mis));
      chk("pass_err_req", {mem_err, dmem_req}, 0);
    end else begin
      chk("issue_stall", 32'(mem_stall), 1);
      @(posedge clk); @(negedge clk);
      chk("issue_req", 32'(dmem_req), 1);
      chk("issue_we", 32'(dmem_we), 32'(ex_wmem));
      chk("issue_addr", dmem_addr, {ex_aluR[31:2], 2'b00});
      chk("issue_wdata", dmem_wdata, ex_inB);
      chk("issue_bubble", {mem_wreg, mem_m2reg, mem_branch, mem_misalign}, 0);
      fin = 1'b0;
      for (int k = 0; k < TO && !fin; k++) begin
        if (k == delay) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
          #1;
          chk("ack_stall", 32'(mem_stall), 0);
          @(posedge clk); @(negedge clk);
          dmem_ack = 1'b0; dmem_rdata = 32'($urandom);
          chk("ack_req", 32'(dmem_req), 0);
          chk("ack_wreg", 32'(mem_wreg), 32'(ex_wreg));
          chk("ack_m2reg", 32'(mem_m2reg), 32'(ex_m2reg));
          chk("ack_rdata", mem_rdata, ex_m2reg ? rd : 32'd0);
          chk("ack_aluR", mem_aluR, ex_aluR);
          chk("ack_dest", 32'(mem_destR), 32'(ex_destR));
          chk("ack_branch_pc", mem_pc ^ 32'(mem_branch), ex_pc ^ 32'(ex_branch));
          chk("ack_err", 32'(mem_err), 0);
          fin = 1'b1;
        end else if (k == TO - 1) begin
          #1;
          chk("to_stall", 32'(mem_stall), 0);
          chk("to_req_last", 32'(dmem_req), 1);
          @(posedge clk); @(negedge clk);
          chk("to_req", 32'(dmem_req), 0);
          chk("to_err", 32'(mem_err), 1);
          chk("to_bubble", {mem_wreg, mem_m2reg, mem_branch}, 0);
          fin = 1'b1;
        end else begin
          #1;
          chk("wait_stall", 32'(mem_stall), 1);
          chk("wait_req", 32'(dmem_req), 1);
          chk("wait_branch", 32'(mem_branch), 0);
          @(posedge clk); @(negedge clk);
          chk("wait_err", 32'(mem_err), 0);
        end
      end
      chk("txn_finished", 32'(fin), 1);
    end
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    set_ex(0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
    EXE_ins_type = 4'd0; EXE_ins_number = 4'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // ALU op
    set_ex(1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h100);
    run_txn(0, 32'd0);
    // Load, ack after three WAIT cycles
    set_ex(1, 1, 0, 32'h40, 32'h0, 5'd7, 0, 32'h104);
    run_txn(3, 32'hDEADBEEF);
    // Store, ack in first WAIT cycle
    set_ex(0, 0, 1, 32'h80, 32'h55, 5'd0, 0, 32'h108);
    run_txn(0, 32'hCAFEF00D);
    // Misaligned load
    set_ex(1, 1, 0, 32'h42, 32'h0, 5'd3, 1, 32'h10C);
    run_txn(0, 32'd0);
    // Timeout
    set_ex(1, 1, 0, 32'h200, 32'h0, 5'd9, 1, 32'h110);
    run_txn(100, 32'd0);
    // Late ack arriving in IDLE is ignored
    set_ex(1, 0, 0, 32'h77, 32'h0, 5'd2, 1, 32'h114);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("late_stall", 32'(mem_stall), 0);
    @(posedge clk); @(negedge clk);
    chk("late_req", 32'(dmem_req), 0);
    chk("late_wreg_aluR", mem_aluR ^ 32'(mem_wreg), 32'h77 ^ 32'd1);
    chk("late_rdata_err", mem_rdata ^ 32'(mem_err), 32'd0);
    dmem_ack = 1'b0;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = {$urandom, 2'b00};
      case (kind)
        0: set_ex(1'($urandom), 0, 0, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom);
        1: set_ex(1, 1, 0, a, $urandom, 5'($urandom), 1'($urandom), $urandom);
        2: set_ex(0, 0, 1, a, $urandom, 5'd0, 1'($urandom), $urandom);
        default: set_ex(1'($urandom), 1'($urandom), 0, a | 32'($urandom_range(1, 3)),
                        $urandom, 5'($urandom), 1'($urandom), $urandom);
      endcase
      if (kind == 3) ex_wmem = ~ex_m2reg;
      run_txn($urandom_range(0, TO + 1), $urandom);
    end

    // Reset in the middle of WAIT
    set_ex(1, 1, 0, 32'h300, 32'h0, 5'd4, 1, 32'h200);
    #1;
    @(posedge clk); @(negedge clk);
    chk("midwait_req_before", 32'(dmem_req), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midwait_rst");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    set_ex(1, 0, 0, 32'hABC, 32'h0, 5'd6, 0, 32'h204);
    run_txn(0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
